// File: rtl/pong_pkg.sv
// Shared constants for the Pong score display: 7-segment digit patterns and FSM states.
// Segment bit order is {A,B,C,D,E,F,G}, bit 6 = A, 1 = lit.
package pong_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_0     = 7'b1111110;
   localparam logic [6:0] SEG_1     = 7'b0110000;
   localparam logic [6:0] SEG_2     = 7'b1101101;
   localparam logic [6:0] SEG_3     = 7'b1111001;
   localparam logic [6:0] SEG_4     = 7'b0110011;
   localparam logic [6:0] SEG_5     = 7'b1011011;
   localparam logic [6:0] SEG_6     = 7'b1011111;
   localparam logic [6:0] SEG_7     = 7'b1110000;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1111011;

   typedef enum logic {
      ST_PLAY = 1'b0,
      ST_WIN  = 1'b1
   } state_e;

endpackage

// File: rtl/seg7_encoder.sv
// Combinational BCD digit to 7-segment pattern; codes 10..15 give a dark digit.
module seg7_encoder
   import pong_pkg::*;
(
   input  logic [3:0] i_Value,
   output logic [6:0] o_Segments
);

   always_comb begin
      o_Segments = SEG_BLANK;
      case (i_Value)
         4'd0:    o_Segments = SEG_0;
         4'd1:    o_Segments = SEG_1;
         4'd2:    o_Segments = SEG_2;
         4'd3:    o_Segments = SEG_3;
         4'd4:    o_Segments = SEG_4;
         4'd5:    o_Segments = SEG_5;
         4'd6:    o_Segments = SEG_6;
         4'd7:    o_Segments = SEG_7;
         4'd8:    o_Segments = SEG_8;
         4'd9:    o_Segments = SEG_9;
         default: o_Segments = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/score_segment_driver.sv
// Pong score keeper: counts point edges, detects the winner and blinks the winning digit
// until a new game starts. All outputs are registered.
module score_segment_driver
   import pong_pkg::*;
#(
   parameter int unsigned p_WIN_SCORE    = 9,
   parameter int unsigned p_BLINK_CYCLES = 12_500_000
) (
   input  logic       i_Clk,
   input  logic       i_Rst_L,
   input  logic       i_P1_Point,
   input  logic       i_P2_Point,
   input  logic       i_Game_Reset,
   output logic [6:0] o_P1_Segments,
   output logic [6:0] o_P2_Segments,
   output logic       o_Game_Over,
   output logic [1:0] o_Winner
);

   localparam int unsigned CntW = (p_BLINK_CYCLES > 1) ? $clog2(p_BLINK_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast  = CntW'(p_BLINK_CYCLES - 1);
   localparam logic [3:0]      WinScore = 4'(p_WIN_SCORE);

   logic            p1_in_q, p1_prev_q, p2_in_q, p2_prev_q;
   logic            in_valid_q, prev_valid_q;
   logic [3:0]      score1_q, score1_d, score2_q, score2_d;
   state_e          state_q, state_d;
   logic [1:0]      winner_q, winner_d;
   logic            game_over_q;
   logic [CntW-1:0] blink_cnt_q, blink_cnt_d;
   logic            blank_q, blank_d;
   logic [6:0]      p1_seg_q, p2_seg_q, p1_enc, p2_enc;
   logic            p1_rise, p2_rise;

   // An edge needs two genuine post-reset samples, so a level already high at reset release
   // is never counted.
   assign p1_rise = prev_valid_q & p1_in_q & ~p1_prev_q;
   assign p2_rise = prev_valid_q & p2_in_q & ~p2_prev_q;

   always_comb begin
      score1_d    = score1_q;
      score2_d    = score2_q;
      state_d     = state_q;
      winner_d    = winner_q;
      blink_cnt_d = blink_cnt_q;
      blank_d     = blank_q;
      if (i_Game_Reset) begin
         score1_d    = 4'd0;
         score2_d    = 4'd0;
         state_d     = ST_PLAY;
         winner_d    = 2'b00;
         blink_cnt_d = '0;
         blank_d     = 1'b0;
      end else begin
         unique case (state_q)
            ST_PLAY: begin
               if (p1_rise) score1_d = score1_q + 4'd1;
               if (p2_rise) score2_d = score2_q + 4'd1;
               if ((score1_d == WinScore) || (score2_d == WinScore)) begin
                  state_d     = ST_WIN;
                  winner_d    = {score2_d == WinScore, score1_d == WinScore};
                  blink_cnt_d = '0;
                  blank_d     = 1'b0;
               end
            end
            ST_WIN: begin
               if (blink_cnt_q == CntLast) begin
                  blink_cnt_d = '0;
                  blank_d     = ~blank_q;
               end else begin
                  blink_cnt_d = blink_cnt_q + CntW'(1);
               end
            end
         endcase
      end
   end

   seg7_encoder u_p1_enc (
      .i_Value    (score1_q),
      .o_Segments (p1_enc)
   );

   seg7_encoder u_p2_enc (
      .i_Value    (score2_q),
      .o_Segments (p2_enc)
   );

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         p1_in_q      <= 1'b0;
         p1_prev_q    <= 1'b0;
         p2_in_q      <= 1'b0;
         p2_prev_q    <= 1'b0;
         in_valid_q   <= 1'b0;
         prev_valid_q <= 1'b0;
         score1_q     <= 4'd0;
         score2_q     <= 4'd0;
         state_q      <= ST_PLAY;
         winner_q     <= 2'b00;
         game_over_q  <= 1'b0;
         blink_cnt_q  <= '0;
         blank_q      <= 1'b0;
         p1_seg_q     <= SEG_0;
         p2_seg_q     <= SEG_0;
      end else begin
         p1_in_q      <= i_P1_Point;
         p1_prev_q    <= p1_in_q;
         p2_in_q      <= i_P2_Point;
         p2_prev_q    <= p2_in_q;
         in_valid_q   <= 1'b1;
         prev_valid_q <= in_valid_q;
         score1_q     <= score1_d;
         score2_q     <= score2_d;
         state_q      <= state_d;
         winner_q     <= winner_d;
         game_over_q  <= (state_d == ST_WIN);
         blink_cnt_q  <= blink_cnt_d;
         blank_q      <= blank_d;
         // blank_q and winner_q are only non-zero in WIN, so no state qualifier is needed
         p1_seg_q     <= (blank_q && winner_q[0]) ? SEG_BLANK : p1_enc;
         p2_seg_q     <= (blank_q && winner_q[1]) ? SEG_BLANK : p2_enc;
      end
   end

   assign o_P1_Segments = p1_seg_q;
   assign o_P2_Segments = p2_seg_q;
   assign o_Game_Over   = game_over_q;
   assign o_Winner      = winner_q;

endmodule

// File: tb/tb_score_segment_driver.sv
// Directed and random stimulus for score_segment_driver, checked every clock against a
// cycle-counting reference model of the scoring and blink rules.
module tb_score_segment_driver;

   localparam int WIN   = 3;
   localparam int BLINK = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       p1, p2, grst;
   logic [6:0] p1_seg, p2_seg;
   logic       game_over;
   logic [1:0] winner;

   int checks = 0;
   int errors = 0;

   logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

   // reference model state
   int m_s1, m_s2, m_over, m_winner, m_entry, m_edge;
   int m_nsamp, m_last1, m_prev1, m_last2, m_prev2;
   logic [6:0] exp_seg1, exp_seg2;
   logic       exp_over;
   logic [1:0] exp_win;

   always #5 clk = ~clk;

   score_segment_driver #(
      .p_WIN_SCORE    (WIN),
      .p_BLINK_CYCLES (BLINK)
   ) dut (
      .i_Clk         (clk),
      .i_Rst_L       (rst_n),
      .i_P1_Point    (p1),
      .i_P2_Point    (p2),
      .i_Game_Reset  (grst),
      .o_P1_Segments (p1_seg),
      .o_P2_Segments (p2_seg),
      .o_Game_Over   (game_over),
      .o_Winner      (winner)
   );

   function automatic logic [6:0] digit(input int v, input bit blank);
      if (blank || v > 9) return 7'b0000000;
      return seg_tab[v];
   endfunction

   task automatic model_reset();
      m_s1 = 0; m_s2 = 0; m_over = 0; m_winner = 0; m_entry = 0; m_edge = 0;
      m_nsamp = 0; m_last1 = 0; m_prev1 = 0; m_last2 = 0; m_prev2 = 0;
      exp_seg1 = seg_tab[0];
      exp_seg2 = seg_tab[0];
      exp_over = 1'b0;
      exp_win  = 2'b00;
   endtask

   // One clock edge: segments show the game as it stood one edge earlier; a rising edge
   // sampled at one edge scores at the next.
   task automatic model_clock(input bit g, input bit a, input bit b);
      bit blank, r1, r2;
      m_edge++;
      blank = (m_over != 0) && ((((m_edge - 1 - m_entry) / BLINK) % 2) == 1);
      exp_seg1 = digit(m_s1, blank && (m_winner % 2 == 1));
      exp_seg2 = digit(m_s2, blank && (m_winner >= 2));
      r1 = (m_nsamp >= 2) && (m_last1 == 1) && (m_prev1 == 0);
      r2 = (m_nsamp >= 2) && (m_last2 == 1) && (m_prev2 == 0);
      if (g) begin
         m_s1 = 0; m_s2 = 0; m_over = 0; m_winner = 0;
      end else if (m_over == 0) begin
         if (r1) m_s1++;
         if (r2) m_s2++;
         if (m_s1 == WIN || m_s2 == WIN) begin
            m_over   = 1;
            m_winner = (m_s1 == WIN ? 1 : 0) + (m_s2 == WIN ? 2 : 0);
            m_entry  = m_edge;
         end
      end
      m_prev1 = m_last1; m_last1 = int'(a);
      m_prev2 = m_last2; m_last2 = int'(b);
      if (m_nsamp < 2) m_nsamp++;
      exp_over = (m_over != 0);
      exp_win  = 2'(m_winner);
   endtask

   task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".p1_seg"}, p1_seg, exp_seg1);
      check({tag, ".p2_seg"}, p2_seg, exp_seg2);
      check({tag, ".game_over"}, {6'd0, game_over}, {6'd0, exp_over});
      check({tag, ".winner"}, {5'd0, winner}, {5'd0, exp_win});
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_clock(grst, p1, p2);
      #1;
      check_all(tag);
   endtask

   task automatic pulse(input string tag, input bit a, input bit b);
      p1 = a; p2 = b;
      tick(tag);
      p1 = 1'b0; p2 = 1'b0;
      tick(tag);
   endtask

   task automatic new_game(input string tag);
      grst = 1'b1;
      tick(tag);
      grst = 1'b0;
      tick(tag);
   endtask

   initial begin
      rst_n = 1'b0; p1 = 1'b0; p2 = 1'b0; grst = 1'b0;
      model_reset();
      #12;
      check_all("reset");
      check("reset.p1_lit", p1_seg, 7'b1111110);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: idle after reset
      repeat (10) tick("idle");

      // 2: P1 held high for five clocks counts once
      p1 = 1'b1;
      repeat (3) tick("p1_hold");
      check("p1_one_lit", p1_seg, 7'b0110000);
      repeat (2) tick("p1_hold");
      p1 = 1'b0;
      repeat (4) tick("p1_low");

      // 3: three simultaneous points -> draw, both digits blink
      new_game("ng3");
      repeat (3) pulse("both", 1'b1, 1'b1);
      repeat (20) tick("draw_blink");
      check("draw_winner", {5'd0, winner}, 7'd3);

      // 4: P2 wins, P1 edges in WIN are ignored
      new_game("ng4");
      repeat (3) pulse("p2_pt", 1'b0, 1'b1);
      repeat (5) pulse("p1_in_win", 1'b1, 1'b0);
      repeat (6) tick("p2_blink");
      check("p2_winner", {5'd0, winner}, 7'd2);

      // 5: game reset on the same edge a P1 point would be counted
      p1 = 1'b1;
      tick("gr_edge_prep");
      grst = 1'b1;
      tick("gr_edge");
      grst = 1'b0;
      repeat (4) tick("gr_after");
      p1 = 1'b0;
      check("gr_p1_zero", p1_seg, 7'b1111110);
      repeat (2) tick("gr_idle");

      // 6: async reset while blinking
      repeat (3) pulse("p1_win", 1'b1, 1'b0);
      repeat (6) tick("p1_blink");
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) tick("post_rst");

      // random play with occasional new games
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 2) == 0) p1 = ~p1;
         if ($urandom_range(0, 2) == 0) p2 = ~p2;
         grst = ($urandom_range(0, 39) == 0);
         tick("rand");
      end
      grst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
